// File: rtl/axil_ram_slave.sv
// AXI4-Lite slave in front of a byte-lane RAM: independent AW/W capture, one-cycle
// write commit, registered one-cycle reads, SLVERR for addresses outside the window.
module axil_ram_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    output logic [DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready
);
    localparam int         IDX_W       = $clog2(MEM_WORDS);
    localparam int         STRB_W      = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // One extra bit on the offset catches addresses below the base as a borrow.
    logic [ADDR_WIDTH:0] aw_off;
    logic [ADDR_WIDTH:0] ar_off;
    logic                aw_ok;
    logic                ar_ok;
    logic [IDX_W-1:0]    aw_idx;
    logic [IDX_W-1:0]    ar_idx;
    logic [3:0]          addr_lsb_unused;

    assign aw_off = {1'b0, s_axil_awaddr} - {1'b0, BASE_ADDR};
    assign ar_off = {1'b0, s_axil_araddr} - {1'b0, BASE_ADDR};
    assign aw_ok  = !aw_off[ADDR_WIDTH] && (aw_off[ADDR_WIDTH-1:IDX_W+2] == '0);
    assign ar_ok  = !ar_off[ADDR_WIDTH] && (ar_off[ADDR_WIDTH-1:IDX_W+2] == '0);
    assign aw_idx = aw_off[IDX_W+1:2];
    assign ar_idx = ar_off[IDX_W+1:2];
    assign addr_lsb_unused = {aw_off[1:0], ar_off[1:0]};

    logic                  aw_held_q, aw_held_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic                  aw_ok_q, aw_ok_d;
    logic                  w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic commit;
    logic wr_en;

    assign s_axil_awready = !aw_held_q && !bvalid_q;
    assign s_axil_wready  = !w_held_q && !bvalid_q;
    assign s_axil_arready = !rvalid_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = rresp_q;

    assign aw_hs  = s_axil_awvalid && s_axil_awready;
    assign w_hs   = s_axil_wvalid && s_axil_wready;
    assign ar_hs  = s_axil_arvalid && s_axil_arready;
    assign commit = aw_held_q && w_held_q;
    assign wr_en  = commit && aw_ok_q && !rst;

    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        aw_ok_d   = aw_ok_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = aw_idx;
            aw_ok_d   = aw_ok;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axil_wdata;
            wstrb_d  = s_axil_wstrb;
        end
        // Holding flags can only both be set while bvalid is low, so commit never overlaps a response.
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = aw_ok_q ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && s_axil_bready) begin
            bvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = ar_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && s_axil_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
        end
    end

    always_ff @(posedge clk) begin
        aw_idx_q <= aw_idx_d;
        aw_ok_q  <= aw_ok_d;
        wdata_q  <= wdata_d;
        wstrb_q  <= wstrb_d;
    end

    // One RAM per byte lane; the read register samples before the write lands (read-first).
    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_lane
            logic [7:0] mem [MEM_WORDS];
            logic [7:0] rd_lane_q;

            always_ff @(posedge clk) begin
                if (wr_en && wstrb_q[gi]) begin
                    mem[aw_idx_q] <= wdata_q[8*gi +: 8];
                end
                if (rst) begin
                    rd_lane_q <= 8'h00;
                end else if (ar_hs) begin
                    rd_lane_q <= ar_ok ? mem[ar_idx] : 8'h00;
                end
            end

            assign s_axil_rdata[8*gi +: 8] = rd_lane_q;
        end
    endgenerate
endmodule

// File: tb/tb_axil_ram_slave.sv
// Directed and randomized bench for axil_ram_slave against a word-array memory model.
module tb_axil_ram_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [31:0] model [1024];

    axil_ram_slave dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        tests++;
        fails++;
        $error("FAIL %s: got timeout expected handshake", tag);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return (a >> 2) < 1024;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, 32'(awready), 32'd1);
        check({tag, "_wready"}, 32'(wready), 32'd1);
        check({tag, "_arready"}, 32'(arready), 32'd1);
        check({tag, "_bvalid"}, 32'(bvalid), 32'd0);
        check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
        check({tag, "_bresp"}, 32'(bresp), 32'd0);
        check({tag, "_rresp"}, 32'(rresp), 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int stall, input string tag);
        logic [1:0] exp_resp;
        logic aw_pend, w_pend, aw_fire, w_fire;
        int n;
        exp_resp = in_range(a) ? 2'b00 : 2'b10;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        aw_pend = 1'b1; w_pend = 1'b1; n = 0;
        while (aw_pend || w_pend) begin
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            tick;
            if (aw_fire) begin awvalid = 1'b0; aw_pend = 1'b0; end
            if (w_fire) begin wvalid = 1'b0; w_pend = 1'b0; end
            n++;
            if (n > 16 && (aw_pend || w_pend)) begin
                bound_fail({tag, "_wr_hs"});
                awvalid = 1'b0; wvalid = 1'b0;
                return;
            end
        end
        check({tag, "_bvalid_early"}, 32'(bvalid), 32'd0);
        tick;
        check({tag, "_bvalid"}, 32'(bvalid), 32'd1);
        check({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
        for (int i = 0; i < stall; i++) begin
            tick;
            check({tag, "_bvalid_hold"}, 32'(bvalid), 32'd1);
            check({tag, "_bresp_hold"}, 32'(bresp), 32'(exp_resp));
        end
        bready = 1'b1;
        tick;
        bready = 1'b0;
        check({tag, "_bvalid_clr"}, 32'(bvalid), 32'd0);
        if (in_range(a)) model[a[11:2]] = merge(model[a[11:2]], d, s);
        $display("[TB] write %s addr=%h data=%h strb=%h resp=%0d", tag, a, d, s, exp_resp);
    endtask

    task automatic do_read(input logic [31:0] a, input int stall, input string tag);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        int n;
        exp_d = in_range(a) ? model[a[11:2]] : 32'd0;
        exp_r = in_range(a) ? 2'b00 : 2'b10;
        araddr = a; arvalid = 1'b1; n = 0;
        while (!arready) begin
            tick;
            n++;
            if (n > 16) begin bound_fail({tag, "_ar_hs"}); arvalid = 1'b0; return; end
        end
        tick;
        arvalid = 1'b0;
        check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        check({tag, "_rdata"}, rdata, exp_d);
        check({tag, "_rresp"}, 32'(rresp), 32'(exp_r));
        for (int i = 0; i < stall; i++) begin
            tick;
            check({tag, "_rvalid_hold"}, 32'(rvalid), 32'd1);
            check({tag, "_rdata_hold"}, rdata, exp_d);
        end
        rready = 1'b1;
        tick;
        rready = 1'b0;
        check({tag, "_rvalid_clr"}, 32'(rvalid), 32'd0);
        $display("[TB] read  %s addr=%h data=%h resp=%0d", tag, a, exp_d, exp_r);
    endtask

    initial begin
        // Reset state, during and after reset.
        repeat (3) tick;
        check_reset_outputs("rst_during");
        rst = 1'b0;
        tick;
        check_reset_outputs("rst_after");

        // Basic write then read.
        do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, "basic");
        do_read(32'h10, 0, "basic");

        // W three cycles ahead of AW, partial strobes.
        do_write(32'h10, 32'hAABBCCDD, 4'hF, 0, "preload10");
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
        check("split_wready", 32'(wready), 32'd1);
        tick;
        wvalid = 1'b0;
        check("split_wready_low", 32'(wready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("split_awready", 32'(awready), 32'd1);
            check("split_bvalid_idle", 32'(bvalid), 32'd0);
            tick;
        end
        awaddr = 32'h10; awvalid = 1'b1;
        tick;
        awvalid = 1'b0;
        check("split_bvalid_early", 32'(bvalid), 32'd0);
        tick;
        check("split_bvalid", 32'(bvalid), 32'd1);
        check("split_bresp", 32'(bresp), 32'd0);
        bready = 1'b1; tick; bready = 1'b0;
        model[4] = merge(model[4], 32'h11223344, 4'b0101);
        check("split_model", model[4], 32'hAA22CC44);
        do_read(32'h10, 0, "split");

        // Out of range: no aliasing onto word 0.
        do_write(32'h0, 32'h0BADF00D, 4'hF, 0, "preload0");
        do_write(32'h1000, 32'hFFFFFFFF, 4'hF, 0, "oor");
        do_read(32'h1000, 0, "oor");
        do_read(32'h0, 0, "oor_word0");

        // Backpressure on both response channels.
        awaddr = 32'h30; wdata = 32'h5A5A1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h10; arvalid = 1'b1;
        tick;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("bp_rvalid", 32'(rvalid), 32'd1);
        check("bp_rdata", rdata, model[4]);
        tick;
        check("bp_bvalid", 32'(bvalid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick;
            check("bp_bvalid_hold", 32'(bvalid), 32'd1);
            check("bp_bresp_hold", 32'(bresp), 32'd0);
            check("bp_rvalid_hold", 32'(rvalid), 32'd1);
            check("bp_rdata_hold", rdata, model[4]);
            check("bp_awready_low", 32'(awready), 32'd0);
            check("bp_wready_low", 32'(wready), 32'd0);
            check("bp_arready_low", 32'(arready), 32'd0);
        end
        bready = 1'b1; rready = 1'b1;
        tick;
        bready = 1'b0; rready = 1'b0;
        check("bp_bvalid_clr", 32'(bvalid), 32'd0);
        check("bp_rvalid_clr", 32'(rvalid), 32'd0);
        model[12] = 32'h5A5A1234;
        do_read(32'h30, 0, "bp_after");

        // Read completes while a write response is stalled.
        awaddr = 32'h34; wdata = 32'h00000077; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        tick;
        check("stall_bvalid", 32'(bvalid), 32'd1);
        do_read(32'h10, 0, "rd_during_stall");
        check("stall_bvalid_still", 32'(bvalid), 32'd1);
        bready = 1'b1; tick; bready = 1'b0;
        model[13] = 32'h00000077;
        do_read(32'h34, 0, "stall_after");

        // Read-first collision on word 0x20.
        do_write(32'h20, 32'h1, 4'hF, 0, "coll_pre");
        awaddr = 32'h20; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h20; arvalid = 1'b1;
        check("coll_arready", 32'(arready), 32'd1);
        tick;
        arvalid = 1'b0;
        check("coll_bvalid", 32'(bvalid), 32'd1);
        check("coll_rvalid", 32'(rvalid), 32'd1);
        check("coll_rdata_old", rdata, 32'h1);
        bready = 1'b1; rready = 1'b1; tick; bready = 1'b0; rready = 1'b0;
        model[8] = 32'h2;
        do_read(32'h20, 0, "coll_new");

        // Reset with an AW held, then with a read response pending.
        awaddr = 32'h10; awvalid = 1'b1;
        tick;
        awvalid = 1'b0;
        check("rstmid_awready_low", 32'(awready), 32'd0);
        rst = 1'b1; tick; rst = 1'b0;
        check_reset_outputs("rstmid_aw");
        for (int i = 0; i < 3; i++) begin
            tick;
            check("rstmid_no_bvalid", 32'(bvalid), 32'd0);
        end
        araddr = 32'h10; arvalid = 1'b1;
        tick;
        arvalid = 1'b0;
        check("rstmid_rvalid", 32'(rvalid), 32'd1);
        rst = 1'b1; tick; rst = 1'b0;
        check_reset_outputs("rstmid_ar");
        do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, "post_rst");
        do_read(32'h10, 0, "post_rst");

        // Randomized traffic over a 16-word window plus out-of-range addresses.
        for (int i = 0; i < 16; i++) do_write(32'h100 + i * 4, $urandom, 4'hF, 0, "rnd_init");
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 7) == 0) a = 32'h1000 + ($urandom_range(0, 255) << 2);
            else a = 32'h100 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), "rnd_wr");
            else
                do_read(a, $urandom_range(0, 3), "rnd_rd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
